// File: rtl/gate_truth_checker.sv
// Self-test driver/checker for a two-input gate bank: applies five stimulus vectors,
// samples the 8-bit response after a settle window and accumulates mismatches.
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] resp_in,
  output logic       a_out,
  output logic       b_out,
  output logic       dut_ena_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask,
  output logic [2:0] err_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [2:0] idx_q;
  logic [7:0] settle_q;
  logic       a_q, b_q, ena_q;
  logic       busy_q, done_q, pass_q;
  logic [7:0] fail_mask_q;
  logic [2:0] err_count_q;

  logic [7:0] expected_d;
  logic [7:0] diff_d;
  logic [7:0] fail_mask_d;
  logic [2:0] idx_d;
  logic [2:0] stim_d;

  // Golden response of the ena-gated gate bank for each vector index.
  always_comb begin
    expected_d = 8'h00;
    case (idx_q)
      3'd0:    expected_d = 8'h78;
      3'd1:    expected_d = 8'hCE;
      3'd2:    expected_d = 8'h0E;
      3'd3:    expected_d = 8'hA3;
      default: expected_d = 8'h00;
    endcase
    diff_d      = resp_in ^ expected_d;
    fail_mask_d = fail_mask_q | diff_d;
    idx_d       = 3'(idx_q + 3'd1);
    // Stimulus {a, b, ena} for the vector that follows the current one.
    stim_d      = (idx_d == 3'd4) ? 3'b110 : {idx_d[1], idx_d[0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      settle_q    <= 8'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      ena_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 8'h00;
      err_count_q <= 3'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= DRIVE;
            idx_q       <= 3'd0;
            fail_mask_q <= 8'h00;
            err_count_q <= 3'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            ena_q       <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        DRIVE: begin
          state_q  <= SETTLE;
          settle_q <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_q == 8'd0) begin
            state_q <= SAMPLE;
          end else begin
            settle_q <= settle_q - 8'd1;
          end
        end
        SAMPLE: begin
          fail_mask_q <= fail_mask_d;
          if (diff_d != 8'h00) begin
            err_count_q <= 3'(err_count_q + 3'd1);
          end
          if (idx_q == 3'd4) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_mask_d == 8'h00);
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            ena_q   <= 1'b0;
          end else begin
            state_q <= DRIVE;
            idx_q   <= idx_d;
            {a_q, b_q, ena_q} <= stim_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_out       = a_q;
  assign b_out       = b_q;
  assign dut_ena_out = ena_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_mask   = fail_mask_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: a behavioural gate bank answers the stimulus,
// with modes for an ideal bank, a stuck NAND output and a bank that ignores its enable.
module tb_gate_truth_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] resp_in;
  logic       a_out, b_out, dut_ena_out;
  logic       busy, done, pass;
  logic [7:0] fail_mask;
  logic [2:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = 0;   // 0 ideal, 1 NAND stuck at 0, 2 enable ignored

  always #5 clk = ~clk;

  gate_truth_checker dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .resp_in     (resp_in),
    .a_out       (a_out),
    .b_out       (b_out),
    .dut_ena_out (dut_ena_out),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_mask   (fail_mask),
    .err_count   (err_count)
  );

  logic [7:0] gates;
  always_comb begin
    gates = {b_out, ~a_out, ~(a_out ^ b_out), ~(a_out | b_out), ~(a_out & b_out),
             a_out ^ b_out, a_out | b_out, a_out & b_out};
    resp_in = dut_ena_out ? gates : 8'h00;
    if (mode == 1) resp_in = resp_in & 8'hF7;
    if (mode == 2) resp_in = gates;
  end

  // Pulse (or hold) start, then count edges from the accept edge until done rises.
  task automatic do_run(input bit hold, output int lat, output logic busy0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    busy0 = busy;
    lat = 0;
    if (!hold) start = 1'b0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    $display("run mode=%0d hold=%0d latency=%0d pass=%0b fail_mask=%h err_count=%0d",
             mode, hold, lat, pass, fail_mask, err_count);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({a_out, b_out, dut_ena_out, busy, done, pass} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000", {a_out, b_out, dut_ena_out, busy, done, pass});
    end
    n_checks++;
    if ({fail_mask, err_count} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_status: got mask=%h err=%0d expected 00/0", fail_mask, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic check_result(input string name, input int lat, input logic busy0,
                              input logic exp_pass, input logic [7:0] exp_mask,
                              input logic [2:0] exp_err);
    n_checks++;
    if (busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_busy_on_accept: got %b expected 1", name, busy0);
    end
    n_checks++;
    if (lat !== 30) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d expected 30", name, lat);
    end
    n_checks++;
    if ({done, busy, pass} !== {1'b1, 1'b0, exp_pass}) begin
      n_fail++;
      $display("FAIL %s_flags: got done/busy/pass=%b expected %b", name, {done, busy, pass}, {1'b1, 1'b0, exp_pass});
    end
    n_checks++;
    if (fail_mask !== exp_mask) begin
      n_fail++;
      $display("FAIL %s_fail_mask: got %h expected %h", name, fail_mask, exp_mask);
    end
    n_checks++;
    if (err_count !== exp_err) begin
      n_fail++;
      $display("FAIL %s_err_count: got %0d expected %0d", name, err_count, exp_err);
    end
    n_checks++;
    if ({a_out, b_out, dut_ena_out} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s_stim_in_done: got %b expected 000", name, {a_out, b_out, dut_ena_out});
    end
  endtask

  task automatic test_ideal;
    int lat;
    logic b0;
    mode = 0;
    do_run(1'b0, lat, b0);
    check_result("ideal", lat, b0, 1'b1, 8'h00, 3'd0);
  endtask

  task automatic test_stuck_nand;
    int lat;
    logic b0;
    mode = 1;
    do_run(1'b0, lat, b0);
    check_result("stuck_nand", lat, b0, 1'b0, 8'h08, 3'd3);
  endtask

  task automatic test_ignore_ena;
    int lat;
    logic b0;
    mode = 2;
    do_run(1'b0, lat, b0);
    check_result("ignore_ena", lat, b0, 1'b0, 8'hA3, 3'd1);
  endtask

  task automatic test_stimulus;
    logic [2:0] exp_stim [5];
    int lat;
    exp_stim[0] = 3'b001; exp_stim[1] = 3'b011; exp_stim[2] = 3'b101;
    exp_stim[3] = 3'b111; exp_stim[4] = 3'b110;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    // Vector k is in SAMPLE during the cycle after edge 6k+5.
    for (int k = 0; k < 5; k++) begin
      while (lat < 6 * k + 5) begin
        @(posedge clk);
        #1;
        lat++;
      end
      $display("sample vector %0d: a=%0b b=%0b ena=%0b", k, a_out, b_out, dut_ena_out);
      n_checks++;
      if ({a_out, b_out, dut_ena_out} !== exp_stim[k]) begin
        n_fail++;
        $display("FAIL stim_vec%0d: got %b expected %b", k, {a_out, b_out, dut_ena_out}, exp_stim[k]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL stim_run_done: got done/pass=%b%b expected 11", done, pass);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic b0;
    mode = 1;
    do_run(1'b1, lat, b0);
    check_result("held_start", lat, b0, 1'b0, 8'h08, 3'd3);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL held_start_single_done: got done/busy=%b expected 10", {done, busy});
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    $display("restart from DONE: done=%0b busy=%0b fail_mask=%h err_count=%0d", done, busy, fail_mask, err_count);
    n_checks++;
    if ({done, busy, pass, fail_mask, err_count} !== {1'b0, 1'b1, 1'b0, 8'h00, 3'd0}) begin
      n_fail++;
      $display("FAIL restart_clear: got done/busy/pass=%b mask=%h err=%0d expected 010/00/0",
               {done, busy, pass}, fail_mask, err_count);
    end
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("second run latency=%0d pass=%0b fail_mask=%h err_count=%0d", lat, pass, fail_mask, err_count);
    check_result("second_run", lat, 1'b1, 1'b0, 8'h08, 3'd3);
  endtask

  task automatic test_reset_midrun;
    int lat;
    logic b0;
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);   // edge 12 after accept
    #1;
    rst_n = 1'b1;
    $display("reset mid-run: busy=%0b done=%0b mask=%h err=%0d", busy, done, fail_mask, err_count);
    n_checks++;
    if ({a_out, b_out, dut_ena_out, busy, done, pass, fail_mask, err_count} !== 17'h0) begin
      n_fail++;
      $display("FAIL midrun_reset_outputs: got %h expected 0",
               {a_out, b_out, dut_ena_out, busy, done, pass, fail_mask, err_count});
    end
    lat = 0;
    while (!done && !busy && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrun_reset_idle: got done/busy=%b expected 00", {done, busy});
    end
    mode = 0;
    do_run(1'b0, lat, b0);
    check_result("after_reset", lat, b0, 1'b1, 8'h00, 3'd0);
  endtask

  initial begin
    test_reset;
    test_ideal;
    test_stuck_nand;
    test_ignore_ena;
    test_stimulus;
    test_back_to_back;
    test_reset_midrun;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
